// File: rtl/wb_cmd_master_pkg.sv
// ============================================================================
// Module      : wb_cmd_master_pkg
// Description : Shared Wishbone defaults and FSM state encoding for the
//               wb_cmd_master initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_cmd_master_pkg;

  // Default bus widths
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // FSM state encoding (2-bit)
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
// ============================================================================
// Module      : wb_timeout_ctr
// Description : Saturating cycle counter with synchronous clear and enable.
//               expire flags the last permitted cycle (count == TIMEOUT-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, holding at the last value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/wb_cmd_master.sv
// ============================================================================
// Module      : wb_cmd_master
// Description : Wishbone pipelined initiator. Converts one valid/ready
//               command into a single Wishbone cycle and reports read data
//               or a timeout error on a one-cycle response strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic          wbm_stl_i,
  input  logic [DW-1:0] wbm_dat_i
);

  state_t state;
  logic   expire;
  logic   accept;

  assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

  // Counts every cycle the bus cycle is open without an ack; stall cycles included
  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (reset),
    .clear  (accept),
    .enable (wbm_cyc_o && !wbm_ack_i),
    .expire (expire)
  );

  // Command FSM with registered Wishbone and response outputs
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_data;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          // Ack beats a simultaneous timeout, and may arrive with the strobe itself
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (expire) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if ((state == ST_REQ) && !wbm_stl_i) begin
            wbm_stb_o <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// ============================================================================
// Module      : tb_wb_cmd_master
// Description : Directed self-checking bench for wb_cmd_master (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_i;
  logic          wbm_stl_i;
  logic [DW-1:0] wbm_dat_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i  (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_stl_i (wbm_stl_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one command for one edge; returns in cycle T1
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Hard bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
    wbm_ack_i = 1'b0; wbm_stl_i = 1'b0; wbm_dat_i = '0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    tick();

    // 1. Write 0x3000_0000 <- 1, then read it back, zero-wait responder
    issue(1'b1, 32'h3000_0000, 32'h1);
    chk("w_t1_cyc", wbm_cyc_o, 1);
    chk("w_t1_stb", wbm_stb_o, 1);
    chk("w_t1_we", wbm_we_o, 1);
    chk("w_t1_adr", wbm_adr_o, 32'h3000_0000);
    chk("w_t1_dat", wbm_dat_o, 32'h1);
    chk("w_t1_ready", cmd_ready, 0);
    chk("w_t1_busy", busy, 1);
    tick();
    chk("w_t2_cyc", wbm_cyc_o, 1);
    chk("w_t2_stb", wbm_stb_o, 0);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("w_t3_cyc", wbm_cyc_o, 0);
    chk("w_t3_rsp_valid", rsp_valid, 1);
    chk("w_t3_err", rsp_err, 0);
    chk("w_t3_data", rsp_data, 0);
    tick();
    chk("w_t4_rsp_valid", rsp_valid, 0);
    chk("w_t4_ready", cmd_ready, 1);
    chk("w_t4_busy", busy, 0);

    issue(1'b0, 32'h3000_0000, 32'h0);
    chk("r_t1_cyc", wbm_cyc_o, 1);
    chk("r_t1_we", wbm_we_o, 0);
    tick();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'hDEAD_BEEF;
    chk("r_t3_rsp_valid", rsp_valid, 1);
    chk("r_t3_data", rsp_data, 32'h1);
    chk("r_t3_err", rsp_err, 0);
    tick();
    chk("r_t4_data_held", rsp_data, 32'h1);
    chk("r_t4_ready", cmd_ready, 1);

    // 2. Three stall cycles, ack one cycle after strobe acceptance
    issue(1'b1, 32'h0000_0040, 32'hA5A5_0001);
    wbm_stl_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk("st_stb_held", wbm_stb_o, 1);
      chk("st_adr_stable", wbm_adr_o, 32'h0000_0040);
      chk("st_dat_stable", wbm_dat_o, 32'hA5A5_0001);
      tick();
    end
    wbm_stl_i = 1'b0;
    chk("st_t4_stb", wbm_stb_o, 1);
    tick();
    chk("st_t5_stb", wbm_stb_o, 0);
    chk("st_t5_cyc", wbm_cyc_o, 1);
    chk("st_t5_adr", wbm_adr_o, 32'h0000_0040);
    chk("st_t5_rsp_valid", rsp_valid, 0);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("st_t6_rsp_valid", rsp_valid, 1);
    chk("st_t6_data", rsp_data, 0);
    tick();

    // 3. Timeout: no ack for 8 cycles
    wbm_dat_i = 32'h5A5A_5A5A;
    issue(1'b0, 32'h0000_0080, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      chk("to_cyc_high", wbm_cyc_o, 1);
      chk("to_no_rsp", rsp_valid, 0);
      tick();
    end
    chk("to_t9_cyc", wbm_cyc_o, 0);
    chk("to_t9_stb", wbm_stb_o, 0);
    chk("to_t9_rsp_valid", rsp_valid, 1);
    chk("to_t9_err", rsp_err, 1);
    chk("to_t9_data", rsp_data, 0);
    tick();
    chk("to_t10_ready", cmd_ready, 1);

    // 4. cmd_valid held across three back-to-back reads
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'(4 * i);
      chk("b2b_ready", cmd_ready, 1);
      tick();
      if (i == 2) cmd_valid = 1'b0;
      chk("b2b_adr", wbm_adr_o, 32'(4 * i));
      chk("b2b_cyc", wbm_cyc_o, 1);
      tick();
      chk("b2b_t2_rsp_valid", rsp_valid, 0);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'(32'h100 + i);
      tick();
      wbm_ack_i = 1'b0;
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_rsp_data", rsp_data, 32'(32'h100 + i));
      tick();
      chk("b2b_t4_cyc", wbm_cyc_o, 0);
      chk("b2b_t4_rsp_valid", rsp_valid, 0);
    end
    tick();
    chk("b2b_no_extra", wbm_cyc_o, 0);

    // 5. Reset while waiting for ack
    issue(1'b0, 32'h0000_000C, 32'h0);
    tick();
    chk("rw_wait_cyc", wbm_cyc_o, 1);
    chk("rw_wait_stb", wbm_stb_o, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_cyc", wbm_cyc_o, 0);
    chk("rw_stb", wbm_stb_o, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_ready", cmd_ready, 1);
    tick();
    chk("rw_no_rsp", rsp_valid, 0);
    issue(1'b1, 32'h0000_0010, 32'h1234_5678);
    tick();
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("rw_next_rsp_valid", rsp_valid, 1);
    chk("rw_next_err", rsp_err, 0);
    tick();

    // 6. Spurious ack in IDLE, then ack in the final timeout cycle
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("sp_cyc", wbm_cyc_o, 0);
    chk("sp_rsp_valid", rsp_valid, 0);
    tick();
    chk("sp_rsp_valid2", rsp_valid, 0);
    issue(1'b0, 32'h0000_0014, 32'h0);
    for (int k = 1; k < 8; k++) tick();
    chk("late_t8_cyc", wbm_cyc_o, 1);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0077;
    tick();
    wbm_ack_i = 1'b0;
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_err", rsp_err, 0);
    chk("late_data", rsp_data, 32'h0000_0077);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
